// File: rtl/voice_scheduler_pkg.sv
// Shared types and helpers for the voice scheduler: event FSM encodings,
// a one-hot builder and a lowest-set-index priority encoder.
package voice_scheduler_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOOKUP = 2'd1,
      ST_COMMIT = 2'd2
   } ev_state_t;

   // Helpers work on a fixed wide vector; callers zero-extend and truncate.
   localparam int unsigned CHAN_MAX = 64;
   typedef logic [CHAN_MAX-1:0] chan_vec_t;

   function automatic chan_vec_t onehot(input int unsigned idx);
      chan_vec_t v;
      v = 64'd1 << idx;
      return v;
   endfunction

   function automatic int unsigned lowest_set(input chan_vec_t v);
      int unsigned idx;
      idx = 32'd0;
      for (int i = CHAN_MAX - 1; i >= 0; i--) begin
         if (v[i]) begin
            idx = i;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/voice_scheduler_alloc.sv
// voice_alloc: combinational match/free vectors for the pending event and
// priority encode of the registered vectors into a channel index.
module voice_alloc
   import voice_scheduler_pkg::*;
#(
   parameter int unsigned NUM_CHAN = 16,
   parameter int unsigned NOTE_W   = 7,
   parameter int unsigned CHAN_W   = $clog2(NUM_CHAN)
) (
   input  logic [NUM_CHAN-1:0] note_enable,
   input  logic [NOTE_W-1:0]   notes [NUM_CHAN],
   input  logic [NOTE_W-1:0]   key,
   output logic [NUM_CHAN-1:0] match_vec,
   output logic [NUM_CHAN-1:0] free_vec,
   input  logic [NUM_CHAN-1:0] match_sel,
   input  logic [NUM_CHAN-1:0] free_sel,
   output logic [CHAN_W-1:0]   match_idx,
   output logic [CHAN_W-1:0]   free_idx,
   output logic                match_found,
   output logic                free_found
);

   chan_vec_t match_wide_s;
   chan_vec_t free_wide_s;

   // Only held channels can match; released channels count as free.
   always_comb begin
      match_vec = '0;
      free_vec  = '0;
      for (int i = 0; i < int'(NUM_CHAN); i++) begin
         match_vec[i] = note_enable[i] && (notes[i] == key);
         free_vec[i]  = ~note_enable[i];
      end
   end

   // Priority encode of the vectors captured during lookup
   always_comb begin
      match_wide_s                = '0;
      free_wide_s                 = '0;
      match_wide_s[NUM_CHAN-1:0]  = match_sel;
      free_wide_s[NUM_CHAN-1:0]   = free_sel;
      match_idx   = CHAN_W'(lowest_set(match_wide_s));
      free_idx    = CHAN_W'(lowest_set(free_wide_s));
      match_found = |match_sel;
      free_found  = |free_sel;
   end

endmodule

// File: rtl/voice_scheduler.sv
// Polyphonic voice scheduler: allocates note events to channels and sweeps the
// channels round-robin for the modulator. Optional VOICE_STEAL_EN enables stealing.
module voice_scheduler
   import voice_scheduler_pkg::*;
#(
   parameter int unsigned NUM_BITS    = 32,
   parameter int unsigned NUM_CHAN    = 16,
   parameter int unsigned NOTE_W      = 7,
   parameter int unsigned SLOT_CYCLES = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ev_valid,
   output logic                ev_ready,
   input  logic                ev_on,
   input  logic [NOTE_W-1:0]   ev_note,
   input  logic [NUM_BITS-1:0] ev_tw,
   output logic [NUM_CHAN-1:0] curr_note,
   output logic [NUM_CHAN-1:0] note_enable,
   output logic [NUM_CHAN-1:0] acc_en,
   output logic [NUM_BITS-1:0] tuning_word,
   output logic                sweep_done,
   output logic                ev_drop
);

   localparam int unsigned CHAN_W = $clog2(NUM_CHAN);
   localparam int unsigned SLOT_W = $clog2(SLOT_CYCLES);
   localparam logic [CHAN_W-1:0] LAST_CHAN = CHAN_W'(NUM_CHAN - 1);
   localparam logic [CHAN_W-1:0] CHAN_ONE  = CHAN_W'(1'b1);
   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOT_CYCLES - 1);
   localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1'b1);

   ev_state_t             state_r;
   logic                  ev_on_r;
   logic [NOTE_W-1:0]     ev_note_r;
   logic [NUM_BITS-1:0]   ev_tw_r;
   logic [NUM_CHAN-1:0]   match_r;
   logic [NUM_CHAN-1:0]   free_r;
   logic [NUM_CHAN-1:0]   note_en_r;
   logic [NOTE_W-1:0]     notes_r [NUM_CHAN];
   logic [NUM_BITS-1:0]   tw_r [NUM_CHAN];
`ifdef VOICE_STEAL_EN
   logic [CHAN_W-1:0]     steal_r;
`endif

   logic [SLOT_W-1:0]     slot_r;
   logic [CHAN_W-1:0]     ptr_r;
   logic [SLOT_W-1:0]     slot_next_s;
   logic [CHAN_W-1:0]     ptr_next_s;
   logic [NUM_CHAN-1:0]   onehot_next_s;

   logic [NUM_CHAN-1:0]   match_s;
   logic [NUM_CHAN-1:0]   free_s;
   logic [CHAN_W-1:0]     match_idx_s;
   logic [CHAN_W-1:0]     free_idx_s;
   logic                  match_found_s;
   logic                  free_found_s;

   voice_alloc #(
      .NUM_CHAN (NUM_CHAN),
      .NOTE_W   (NOTE_W),
      .CHAN_W   (CHAN_W)
   ) u_alloc (
      .note_enable (note_en_r),
      .notes       (notes_r),
      .key         (ev_note_r),
      .match_vec   (match_s),
      .free_vec    (free_s),
      .match_sel   (match_r),
      .free_sel    (free_r),
      .match_idx   (match_idx_s),
      .free_idx    (free_idx_s),
      .match_found (match_found_s),
      .free_found  (free_found_s)
   );

   // Event FSM: accept, look up, commit channel state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r   <= ST_IDLE;
         ev_ready  <= 1'b0;
         ev_drop   <= 1'b0;
         ev_on_r   <= 1'b0;
         ev_note_r <= '0;
         ev_tw_r   <= '0;
         match_r   <= '0;
         free_r    <= '0;
         note_en_r <= '0;
         for (int i = 0; i < int'(NUM_CHAN); i++) begin
            notes_r[i] <= '0;
            tw_r[i]    <= '0;
         end
`ifdef VOICE_STEAL_EN
         steal_r   <= '0;
`endif
      end else begin
         ev_drop <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (ev_valid && ev_ready) begin
                  ev_on_r   <= ev_on;
                  ev_note_r <= ev_note;
                  ev_tw_r   <= ev_tw;
                  ev_ready  <= 1'b0;
                  state_r   <= ST_LOOKUP;
               end else begin
                  ev_ready  <= 1'b1;
               end
            end
            ST_LOOKUP: begin
               match_r <= match_s;
               free_r  <= free_s;
`ifndef VOICE_STEAL_EN
               // Drop is known here so the pulse lands in the commit cycle.
               ev_drop <= ev_on_r && !(|match_s) && !(|free_s);
`endif
               state_r <= ST_COMMIT;
            end
            ST_COMMIT: begin
               if (ev_on_r) begin
                  if (match_found_s) begin
                     tw_r[match_idx_s] <= ev_tw_r;
                  end else if (free_found_s) begin
                     note_en_r[free_idx_s] <= 1'b1;
                     notes_r[free_idx_s]   <= ev_note_r;
                     tw_r[free_idx_s]      <= ev_tw_r;
                  end else begin
`ifdef VOICE_STEAL_EN
                     notes_r[steal_r] <= ev_note_r;
                     tw_r[steal_r]    <= ev_tw_r;
                     steal_r          <= (steal_r == LAST_CHAN) ? '0 : steal_r + CHAN_ONE;
`endif
                  end
               end else if (match_found_s) begin
                  // Release keeps the stored tuning word so the decay holds pitch.
                  note_en_r[match_idx_s] <= 1'b0;
               end
               ev_ready <= 1'b1;
               state_r  <= ST_IDLE;
            end
            default: begin
               ev_ready <= 1'b0;
               state_r  <= ST_IDLE;
            end
         endcase
      end
   end

   // Next slot / channel pointer of the round-robin sweep
   always_comb begin
      slot_next_s = slot_r;
      ptr_next_s  = ptr_r;
      if (slot_r == LAST_SLOT) begin
         slot_next_s = '0;
         if (ptr_r == LAST_CHAN) begin
            ptr_next_s = '0;
         end else begin
            ptr_next_s = ptr_r + CHAN_ONE;
         end
      end else begin
         slot_next_s = slot_r + SLOT_ONE;
         ptr_next_s  = ptr_r;
      end
   end

   assign onehot_next_s = NUM_CHAN'(onehot(32'(ptr_next_s)));

   // Sweep counters and registered modulator-facing outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         slot_r      <= '0;
         ptr_r       <= '0;
         curr_note   <= {{(NUM_CHAN-1){1'b0}}, 1'b1};
         note_enable <= '0;
         acc_en      <= '0;
         tuning_word <= '0;
         sweep_done  <= 1'b0;
      end else begin
         slot_r      <= slot_next_s;
         ptr_r       <= ptr_next_s;
         curr_note   <= onehot_next_s;
         note_enable <= note_en_r;
         acc_en      <= (slot_next_s == LAST_SLOT) ? onehot_next_s : '0;
         tuning_word <= tw_r[ptr_next_s];
         sweep_done  <= (slot_next_s == LAST_SLOT) && (ptr_next_s == LAST_CHAN);
      end
   end

endmodule

// File: tb/tb_voice_scheduler.sv
// Self-checking bench for voice_scheduler: sweep timing model plus an event
// scoreboard holding the expected gate vector and drop count per event.
module tb_voice_scheduler;

   localparam int NB = 32;
   localparam int NC = 16;
   localparam int NW = 7;
   localparam int SC = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          ev_valid = 1'b0;
   logic          ev_ready;
   logic          ev_on = 1'b0;
   logic [NW-1:0] ev_note = '0;
   logic [NB-1:0] ev_tw = '0;
   logic [NC-1:0] curr_note;
   logic [NC-1:0] note_enable;
   logic [NC-1:0] acc_en;
   logic [NB-1:0] tuning_word;
   logic          sweep_done;
   logic          ev_drop;

   int checks = 0;
   int errors = 0;
   int edges;

   typedef struct {
      logic [NC-1:0] ne;
      int            drops;
   } exp_t;
   exp_t sb[$];

   voice_scheduler #(
      .NUM_BITS(NB), .NUM_CHAN(NC), .NOTE_W(NW), .SLOT_CYCLES(SC)
   ) dut (
      .clk(clk), .rst(rst), .ev_valid(ev_valid), .ev_ready(ev_ready),
      .ev_on(ev_on), .ev_note(ev_note), .ev_tw(ev_tw),
      .curr_note(curr_note), .note_enable(note_enable), .acc_en(acc_en),
      .tuning_word(tuning_word), .sweep_done(sweep_done), .ev_drop(ev_drop)
   );

   always #5 clk = ~clk;

   // Timebase of the sweep model: clock edges since reset release
   always @(posedge clk or negedge rst) begin
      if (!rst) edges <= 0;
      else      edges <= edges + 1;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic send_event(input logic on, input int note, input logic [NB-1:0] tw,
                             input logic [NC-1:0] exp_ne, input int exp_drops, input string tag);
      exp_t e;
      int n;
      int drops;
      logic [NC-1:0] ne_before;
      logic [NC-1:0] ne_mid;
      sb.push_back('{exp_ne, exp_drops});
      ev_on = on;
      ev_note = NW'(note);
      ev_tw = tw;
      ev_valid = 1'b1;
      n = 0;
      while (ev_ready !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (n >= 20) begin
         errors++;
         $display("FAIL %s handshake: ev_ready=%b after %0d cycles, required 1", tag, ev_ready, n);
      end
      ne_before = note_enable;
      tick();
      ev_valid = 1'b0;
      checks++;
      if (ev_ready !== 1'b0) begin
         errors++;
         $display("FAIL %s busy: ev_ready=%b, required 0", tag, ev_ready);
      end
      drops = (ev_drop === 1'b1) ? 1 : 0;
      ne_mid = note_enable;
      for (int k = 0; k < 3; k++) begin
         if (k == 2) ne_mid = note_enable;
         tick();
         if (ev_drop === 1'b1) drops++;
      end
      e = sb.pop_front();
      checks++;
      if (ne_mid !== ne_before) begin
         errors++;
         $display("FAIL %s latency: note_enable=%h two cycles after accept, required %h", tag, ne_mid, ne_before);
      end
      checks++;
      if (note_enable !== e.ne) begin
         errors++;
         $display("FAIL %s note_enable: got %h, required %h", tag, note_enable, e.ne);
      end
      checks++;
      if (drops != e.drops) begin
         errors++;
         $display("FAIL %s ev_drop: got %0d pulses, required %0d", tag, drops, e.drops);
      end
   endtask

   task automatic check_tw(input int ch, input logic [NB-1:0] exp, input string tag);
      int n;
      logic [NC-1:0] want;
      want = 16'h0001 << ch;
      n = 0;
      while (curr_note !== want && n < 100) begin
         tick();
         n++;
      end
      checks++;
      if (n >= 100 || tuning_word !== exp) begin
         errors++;
         $display("FAIL %s tuning_word: got %h (curr_note %h), required %h in ch%0d slot",
                  tag, tuning_word, curr_note, exp, ch);
      end
   endtask

   task automatic test_reset;
      logic [82:0] exp_v;
      exp_v = {1'b0, 16'h0001, 16'h0000, 16'h0000, 32'h0000_0000, 1'b0, 1'b0};
      rst = 1'b0;
      repeat (5) tick();
      checks++;
      if ({ev_ready, curr_note, note_enable, acc_en, tuning_word, sweep_done, ev_drop} !== exp_v) begin
         errors++;
         $display("FAIL reset_values: got %h, required %h",
                  {ev_ready, curr_note, note_enable, acc_en, tuning_word, sweep_done, ev_drop}, exp_v);
      end
      rst = 1'b1;
      checks++;
      if (ev_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_ready: got %b, required 0", ev_ready);
      end
      tick();
      checks++;
      if (ev_ready !== 1'b1 || curr_note !== 16'h0001 || acc_en !== 16'h0000) begin
         errors++;
         $display("FAIL first_cycle: ev_ready=%b curr_note=%h acc_en=%h, required 1 0001 0000",
                  ev_ready, curr_note, acc_en);
      end
   endtask

   task automatic test_sweep;
      int slot;
      int ptr;
      int sd_first;
      int sd_second;
      logic [32:0] got;
      logic [32:0] exp_v;
      logic [NC-1:0] oh;
      sd_first = -1;
      sd_second = -1;
      while (edges < 140) begin
         slot = edges % SC;
         ptr = (edges / SC) % NC;
         oh = 16'h0001 << ptr;
         exp_v = {oh, (slot == SC - 1) ? oh : 16'h0000, (slot == SC - 1) && (ptr == NC - 1)};
         got = {curr_note, acc_en, sweep_done};
         checks++;
         if (got !== exp_v) begin
            errors++;
            $display("FAIL sweep cycle %0d: got %h, required %h", edges, got, exp_v);
         end
         if (sweep_done === 1'b1) begin
            if (sd_first < 0) sd_first = edges;
            else if (sd_second < 0) sd_second = edges;
         end
         tick();
      end
      checks++;
      if (sd_first != 63 || sd_second != 127) begin
         errors++;
         $display("FAIL sweep_done_period: pulses at %0d and %0d, required 63 and 127", sd_first, sd_second);
      end
   endtask

   task automatic test_alloc;
      send_event(1'b1, 60, 32'h0123_4567, 16'h0001, 0, "on60");
      check_tw(0, 32'h0123_4567, "on60");
      send_event(1'b1, 64, 32'h0000_0064, 16'h0003, 0, "on64");
      check_tw(1, 32'h0000_0064, "on64");
      send_event(1'b0, 60, 32'h0, 16'h0002, 0, "off60");
      check_tw(0, 32'h0123_4567, "off60_keeps_tw");
      send_event(1'b0, 64, 32'h0, 16'h0000, 0, "off64");
   endtask

   task automatic test_retrigger;
      send_event(1'b1, 60, 32'hAAAA_0001, 16'h0001, 0, "retrig_a");
      send_event(1'b1, 60, 32'hBBBB_0002, 16'h0001, 0, "retrig_b");
      check_tw(0, 32'hBBBB_0002, "retrig_b");
      send_event(1'b0, 99, 32'h0, 16'h0001, 0, "off99");
      send_event(1'b0, 60, 32'h0, 16'h0000, 0, "off60b");
   endtask

   task automatic test_full;
      for (int i = 0; i < NC; i++) begin
         send_event(1'b1, 40 + i, 32'(40 + i) << 8, 16'hFFFF >> (NC - 1 - i), 0, "fill");
      end
`ifdef VOICE_STEAL_EN
      send_event(1'b1, 70, 32'h0000_7070, 16'hFFFF, 0, "steal70");
      check_tw(0, 32'h0000_7070, "steal70");
      send_event(1'b0, 70, 32'h0, 16'hFFFE, 0, "off70");
`else
      send_event(1'b1, 70, 32'h0000_7070, 16'hFFFF, 1, "drop70");
      check_tw(0, 32'h0000_2800, "drop70_no_change");
      send_event(1'b0, 70, 32'h0, 16'hFFFF, 0, "off70");
`endif
   endtask

   task automatic test_reset_mid;
      int n;
      ev_on = 1'b1;
      ev_note = 7'd20;
      ev_tw = 32'h0000_2020;
      ev_valid = 1'b1;
      n = 0;
      while (ev_ready !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      tick();
      ev_valid = 1'b0;
      rst = 1'b0;
      #1;
      checks++;
      if (note_enable !== 16'h0000 || ev_ready !== 1'b0 || curr_note !== 16'h0001) begin
         errors++;
         $display("FAIL midreset_async: note_enable=%h ev_ready=%b curr_note=%h, required 0000 0 0001",
                  note_enable, ev_ready, curr_note);
      end
      repeat (2) tick();
      rst = 1'b1;
      checks++;
      if (ev_ready !== 1'b0) begin
         errors++;
         $display("FAIL midreset_release: ev_ready=%b, required 0", ev_ready);
      end
      tick();
      checks++;
      if (ev_ready !== 1'b1) begin
         errors++;
         $display("FAIL midreset_ready: ev_ready=%b, required 1", ev_ready);
      end
      repeat (5) tick();
      checks++;
      if (note_enable !== 16'h0000) begin
         errors++;
         $display("FAIL midreset_lost: note_enable=%h, required 0000", note_enable);
      end
      send_event(1'b1, 21, 32'h0000_2121, 16'h0001, 0, "after_reset");
      check_tw(0, 32'h0000_2121, "after_reset");
   endtask

   initial begin
      test_reset();
      test_sweep();
      test_alloc();
      test_retrigger();
      test_full();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
